// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, IDLE/WAIT memory fetch FSM, instruction register and field decode.
// Optional: define MISALIGN_TRAP_EN to block fetches from a misaligned PC and raise a sticky misalign_err.
module instr_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCEn,
    input  logic [1:0]  PCSource,
    input  logic        IRWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ALUOut,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  Op,
    output logic [5:0]  Funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        fetch_busy,
    output logic        ir_valid,
    output logic        misalign_err
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state;
    state_t state_next;
    logic   misalign_hit;
    logic   fetch_start;
    logic   fetch_done;

`ifdef MISALIGN_TRAP_EN
    assign misalign_hit = (state == IDLE) && IRWrite && (pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            misalign_err <= 1'b0;
        else if (misalign_hit)
            misalign_err <= 1'b1;
    end
`else
    assign misalign_hit = 1'b0;
    assign misalign_err = 1'b0;
`endif

    assign fetch_start = (state == IDLE) && IRWrite && !misalign_hit;
    assign fetch_done  = (state == WAIT) && mem_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fetch_start) state_next = WAIT;
            WAIT:    if (mem_ack)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request is a pure function of state so that reset drops it without a clock edge.
    always_comb begin
        mem_req    = 1'b0;
        fetch_busy = 1'b0;
        if (state == WAIT) begin
            mem_req    = 1'b1;
            fetch_busy = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (PCEn) begin
            case (PCSource)
                2'b00:   pc <= ALUResult;
                2'b01:   pc <= ALUOut;
                2'b10:   pc <= {pc[31:28], instr[25:0], 2'b00};
                default: pc <= pc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr <= '0;
            instr    <= '0;
            ir_valid <= 1'b0;
        end else begin
            ir_valid <= fetch_done;
            if (fetch_start)
                mem_addr <= pc;
            if (fetch_done)
                instr <= mem_rdata;
        end
    end

    assign Op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign Funct = instr[5:0];
    assign imm   = {{16{instr[15]}}, instr[15:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic against a transaction-level model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCEn;
    logic [1:0]  PCSource;
    logic        IRWrite;
    logic [31:0] ALUResult;
    logic [31:0] ALUOut;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        fetch_busy;
    logic        ir_valid;
    logic        misalign_err;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .PCEn(PCEn), .PCSource(PCSource), .IRWrite(IRWrite),
        .ALUResult(ALUResult), .ALUOut(ALUOut), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pc(pc), .instr(instr), .Op(Op),
        .Funct(Funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .fetch_busy(fetch_busy),
        .ir_valid(ir_valid), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: one outstanding fetch at most, tracked as "pending".
    logic [31:0] m_pc, m_instr, m_addr;
    logic        m_pending, m_valid, m_err;
    bit          trap_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_instr = '0; m_addr = '0;
        m_pending = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic check_all();
        check("pc", pc, m_pc);
        check("instr", instr, m_instr);
        check("mem_addr", mem_addr, m_addr);
        check("mem_req", {31'd0, mem_req}, {31'd0, m_pending});
        check("fetch_busy", {31'd0, fetch_busy}, {31'd0, m_pending});
        check("ir_valid", {31'd0, ir_valid}, {31'd0, m_valid});
        check("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
        check("Op", {26'd0, Op}, {26'd0, m_instr[31:26]});
        check("rs", {27'd0, rs}, {27'd0, m_instr[25:21]});
        check("rt", {27'd0, rt}, {27'd0, m_instr[20:16]});
        check("rd", {27'd0, rd}, {27'd0, m_instr[15:11]});
        check("Funct", {26'd0, Funct}, {26'd0, m_instr[5:0]});
        check("imm", imm, $signed(m_instr[15:0]));
    endtask

    task automatic cycle(input logic pcen, input logic [1:0] src, input logic irw,
                         input logic [31:0] alur, input logic [31:0] aluo,
                         input logic ack, input logic [31:0] rdata);
        logic [31:0] old_pc;
        PCEn = pcen; PCSource = src; IRWrite = irw;
        ALUResult = alur; ALUOut = aluo; mem_ack = ack; mem_rdata = rdata;
        @(posedge clk);
        old_pc = m_pc;
        if (pcen) begin
            if (src == 2'd0)      m_pc = alur;
            else if (src == 2'd1) m_pc = aluo;
            else if (src == 2'd2) m_pc = {old_pc[31:28], m_instr[25:0], 2'b00};
        end
        m_valid = 1'b0;
        if (m_pending) begin
            if (ack) begin
                m_instr = rdata; m_pending = 1'b0; m_valid = 1'b1;
            end
        end else if (irw) begin
            if (trap_en && old_pc[1:0] != 2'b00) begin
                m_err = 1'b1;
            end else begin
                m_pending = 1'b1; m_addr = old_pc;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 2'd3, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        int unsigned episodes;
        logic        prev_req;
        logic [31:0] alur;
`ifdef MISALIGN_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        reset = 1'b0; PCEn = 1'b0; PCSource = '0; IRWrite = 1'b0;
        ALUResult = '0; ALUOut = '0; mem_ack = 1'b0; mem_rdata = '0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Fetch at PC 0 while PC advances to 4; ack after three WAIT cycles.
        cycle(1'b1, 2'd0, 1'b1, 32'd4, '0, 1'b0, '0);
        check("first_addr", mem_addr, 32'h0);
        check("first_pc", pc, 32'h4);
        cycle(1'b0, 2'd3, 1'b0, '0, '0, 1'b0, 32'hDEAD_BEEF);
        cycle(1'b0, 2'd3, 1'b0, '0, '0, 1'b0, 32'hDEAD_BEEF);
        cycle(1'b0, 2'd3, 1'b0, '0, '0, 1'b1, 32'h8C22_0004);
        check("lw_Op", {26'd0, Op}, 32'h23);
        check("lw_rt", {27'd0, rt}, 32'h2);
        check("lw_imm", imm, 32'h4);
        check("lw_valid", {31'd0, ir_valid}, 32'h1);
        idle_cycle();
        check("valid_pulse", {31'd0, ir_valid}, 32'h0);

        // Jump target composition.
        cycle(1'b1, 2'd0, 1'b1, 32'h4000_0008, '0, 1'b0, '0);
        cycle(1'b0, 2'd3, 1'b0, '0, '0, 1'b1, 32'h0800_0010);
        cycle(1'b1, 2'd2, 1'b0, '0, '0, 1'b0, '0);
        check("jump_pc", pc, 32'h4000_0040);

        // PC wrap.
        cycle(1'b1, 2'd1, 1'b0, '0, 32'hFFFF_FFFC, 1'b0, '0);
        cycle(1'b1, 2'd0, 1'b0, 32'hFFFF_FFFC + 32'd4, '0, 1'b0, '0);
        check("wrap_pc", pc, 32'h0);

        // IRWrite during WAIT and on the completing edge: one episode only.
        episodes = 0; prev_req = 1'b0;
        cycle(1'b0, 2'd3, 1'b1, '0, '0, 1'b0, '0);
        if (mem_req && !prev_req) episodes++; prev_req = mem_req;
        cycle(1'b0, 2'd3, 1'b1, '0, '0, 1'b0, '0);
        if (mem_req && !prev_req) episodes++; prev_req = mem_req;
        cycle(1'b0, 2'd3, 1'b1, '0, '0, 1'b1, 32'h1234_5678);
        if (mem_req && !prev_req) episodes++; prev_req = mem_req;
        idle_cycle();
        if (mem_req && !prev_req) episodes++;
        check("episodes", episodes, 32'd1);
        check("busy_after", {31'd0, fetch_busy}, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0:       alur = $urandom;
                1:       alur = $urandom & 32'hFFFF_FFFC;
                default: alur = m_pc + 32'd4;
            endcase
            cycle($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 2) == 0, alur, $urandom & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 1)), $urandom);
        end

        // Misaligned PC fetch.
        model_reset();
        reset = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 2'd0, 1'b0, 32'h0000_0006, '0, 1'b0, '0);
        cycle(1'b0, 2'd3, 1'b1, '0, '0, 1'b0, '0);
        check("mis_req", {31'd0, mem_req}, trap_en ? 32'h0 : 32'h1);
        check("mis_err", {31'd0, misalign_err}, trap_en ? 32'h1 : 32'h0);
        check("mis_addr", mem_addr, trap_en ? 32'h0 : 32'h6);
        cycle(1'b0, 2'd3, 1'b0, '0, '0, 1'b1, 32'hAAAA_5555);
        cycle(1'b1, 2'd1, 1'b0, '0, 32'h100, 1'b0, '0);
        check("mis_sticky", {31'd0, misalign_err}, trap_en ? 32'h1 : 32'h0);

        // Asynchronous reset in the middle of WAIT, then a stale ack.
        cycle(1'b0, 2'd3, 1'b1, '0, '0, 1'b0, '0);
        check("pre_reset_req", {31'd0, mem_req}, 32'h1);
        reset = 1'b0;
        model_reset();
        #1;
        check("async_req", {31'd0, mem_req}, 32'h0);
        check_all();
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b0, 2'd3, 1'b0, '0, '0, 1'b1, 32'hFFFF_0000);
        check("late_ack_instr", instr, 32'h0);
        check("late_ack_valid", {31'd0, ir_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
